core_div: RTL and testbench
===========================

Name: core_div

Overview:
- Iterative RV32M divider in the EXEC stage. Serves DIV, DIVU, REM and REMU when the decoder selects EXEC_DIV.
- Consumes the decoder's div_op plus the two register operands. Returns one XLEN-bit result through a start/done handshake to the exec engine mux.
- Radix-2 restoring algorithm: one quotient bit per cycle.
- Divide-by-zero and signed-overflow cases take a one-cycle fast path.

Parameters:
- XLEN, 32, operand and result width. Must be at least 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  request. Accepted only in IDLE or DONE state.
- div_op  in  core_pkg::div_op_e (2)  DIV_DIV=00, DIV_DIVU=01, DIV_REM=10, DIV_REMU=11
- a  in  XLEN  dividend (rs1)
- b  in  XLEN  divisor (rs2)
- flush  in  1  abort (trap/kill). Discards any operation in flight.
- busy  out  1  high while in CALC state
- done  out  1  one-cycle pulse: result valid
- result  out  XLEN  quotient or remainder. Held stable until the next accepted start.

Behaviour:
- Reset (rst_n low at a clk edge) state:
  - state=IDLE, busy=0, done=0, result=0, all internal registers 0.
  - Reset mid-CALC abandons the operation; no done is produced.
- States: IDLE, CALC, DONE.
  - IDLE --start--> CALC for normal operands.
  - IDLE --start--> DONE for special cases.
  - CALC: counter counts XLEN iterations, then --> DONE.
  - DONE: lasts one cycle. Goes to IDLE, or to CALC/DONE if start is high in that cycle (back-to-back issue).
  - start in CALC is ignored; the operation in flight continues.
- Accept cycle (cycle 0, start sampled):
  - Latch op, dividend sign, divisor sign and counter=XLEN-1.
  - Signed ops (DIV, REM) convert operands to magnitudes (two's-complement negate if MSB set). Unsigned ops use operands as-is.
  - Latch negq = sign(a) XOR sign(b) and negr = sign(a), signed ops only.
- CALC, each cycle:
  - rem' = {rem[XLEN-1:0], quo[XLEN-1]}, an (XLEN+1)-bit value.
  - trial = rem' − {0, |b|}.
  - If trial is non-negative: rem=trial and shift 1 into quo; otherwise rem=rem' and shift 0 into quo.
  - Counter decrements; the final iteration is the one with counter==0.
- Normal latency: start at cycle 0, XLEN CALC cycles (1..XLEN), done=1 at cycle XLEN+1 (33 for XLEN=32). busy=1 during cycles 1..XLEN.
- Result selection, registered on entry to DONE:
  - DIV: quo, negated if negq.
  - DIVU: quo.
  - REM: rem, negated if negr.
  - REMU: rem.
- Special cases, decided at accept; done at cycle 1; busy never asserted:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a unchanged.
  - Signed overflow (DIV/REM, a=0x8000_0000, b=all-ones): DIV gives 0x8000_0000; REM gives 0.
  - Divide-by-zero takes priority over the overflow check.
- flush:
  - Takes effect at the clk edge: state goes to IDLE, done forced 0 next cycle, result unchanged.
  - flush and start in the same cycle: flush wins; the start is dropped.
  - flush in DONE cycle: the done already visible that cycle stands; no new op is accepted.
- Operands a/b/div_op only need to be valid in the accept cycle; later changes have no effect.
- Width rules:
  - rem register is XLEN+1 bits; quo is XLEN bits; counter is $clog2(XLEN) bits.
  - Negation is XLEN-bit two's complement, modulo 2^XLEN.

Decomposition:
- core_pkg: div_op_e (shared with the decoder) and div_state_e {DIV_IDLE, DIV_CALC, DIV_DONE}.
- Single module; no sub-module. The iteration step is inline combinational logic.

Test Plan:
- DIV a=100, b=7, start at cycle 0 -> busy cycles 1–32; done at cycle 33 with result=14; REM on the same operands -> 2.
- REM a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFF (−1); DIV -> 0xFFFFFFFD (−3); DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIVU a=5, b=0 -> done at cycle 1, result=0xFFFFFFFF, busy never high; REMU a=5, b=0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1; REM on the same operands -> 0.
- Start DIV 100/7, flush at cycle 10 -> state IDLE at cycle 11, no done pulse. Fresh start DIVU 9/3 at cycle 12 -> done at cycle 45, result=3.
- start pulsed again at cycle 5 while busy -> ignored, original result unchanged. rst_n low at cycle 20 mid-CALC -> busy=0, done=0, result=0 next cycle. start held high during the DONE cycle -> second op accepted back-to-back.

Source files
------------

// File: rtl/core_pkg.sv
// Shared EXEC-stage types: divider opcode (also driven by the decoder) and divider FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic div_op_signed(input div_op_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic div_op_rem(input div_op_e op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/core_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module core_div
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  div_op_e         div_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e       state;
  div_op_e          op;
  logic             negq;
  logic             negr;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  divisor;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_neg       = div_op_signed(div_op) & a[XLEN-1];
    b_neg       = div_op_signed(div_op) & b[XLEN-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    div_zero    = (b == '0);
    overflow    = div_op_signed(div_op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special_res = '0;
    // Zero divisor wins over overflow; overflow DIV returns the dividend itself.
    if (div_zero)
      special_res = div_op_rem(div_op) ? a : '1;
    else
      special_res = div_op_rem(div_op) ? '0 : a;
  end

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] rem_low;
  logic [XLEN-1:0] calc_res;

  // A set top bit in rem would mean the shifted partial remainder already exceeds any divisor.
  always_comb begin
    rem_shift = {rem[XLEN-1:0], quo[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor};
    q_bit     = rem[XLEN] | ~trial[XLEN];
    rem_nxt   = q_bit ? trial : rem_shift;
    quo_nxt   = {quo[XLEN-2:0], q_bit};
    rem_low   = rem_nxt[XLEN-1:0];
    calc_res  = '0;
    unique case (op)
      DIV_DIV:  calc_res = negq ? -quo_nxt : quo_nxt;
      DIV_DIVU: calc_res = quo_nxt;
      DIV_REM:  calc_res = negr ? -rem_low : rem_low;
      DIV_REMU: calc_res = rem_low;
      default:  calc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DIV_IDLE;
      op      <= DIV_DIV;
      negq    <= 1'b0;
      negr    <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= DIV_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          DIV_IDLE, DIV_DONE: begin
            if (start) begin
              op      <= div_op;
              negq    <= a_neg ^ b_neg;
              negr    <= a_neg;
              cnt     <= CNT_W'(XLEN - 1);
              rem     <= '0;
              quo     <= a_mag;
              divisor <= b_mag;
              if (div_zero || overflow) begin
                state  <= DIV_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= special_res;
              end else begin
                state <= DIV_CALC;
                busy  <= 1'b1;
              end
            end else begin
              state <= DIV_IDLE;
            end
          end
          DIV_CALC: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              state  <= DIV_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= calc_res;
            end
          end
          default: begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_div.sv
// Self-checking bench for core_div: directed corner cases plus random operations scored
// against plain-arithmetic RV32M division semantics.
module tb_core_div;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  div_op_e     div_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          failures;
  logic [31:0] last_result;

  core_div #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .div_op (div_op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference semantics: SV integer division truncates toward zero, remainder follows dividend.
  function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    sx = int'(x);
    sy = int'(y);
    case (op)
      DIV_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_REMU: return (y == 0) ? x : x % y;
      DIV_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      default: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
    endcase
  endfunction

  function automatic int ref_latency(input div_op_e op, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 1;
    if ((op == DIV_DIV || op == DIV_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one request at a negedge; returns at the negedge of cycle 1 with operands scrambled.
  task automatic apply_stimulus(input div_op_e op, input logic [31:0] av, input logic [31:0] bv);
    start  = 1'b1;
    div_op = op;
    a      = av;
    b      = bv;
    tick();
    start  = 1'b0;
    div_op = div_op_e'(2'($urandom_range(0, 3)));
    a      = $urandom;
    b      = $urandom;
  endtask

  // Current cycle is k0; waits (bounded) for done and checks latency, busy cycles and result.
  task automatic wait_done(input string tag, input int k0, input int exp_lat, input logic [31:0] exp_res);
    int k;
    int busy_n;
    bit seen;
    k      = k0;
    busy_n = 0;
    seen   = 1'b0;
    while (k <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      tick();
      k++;
    end
    check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_output({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check_output({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - k0));
    check_output({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_output({tag, "_result"}, result, exp_res);
    last_result = exp_res;
  endtask

  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] exp_res;
    int          exp_lat;
    exp_res = ref_result(op, av, bv);
    exp_lat = ref_latency(op, av, bv);
    apply_stimulus(op, av, bv);
    wait_done(tag, 1, exp_lat, exp_res);
  endtask

  initial begin
    int          done_cnt;
    div_op_e     rop;
    logic [31:0] ra;
    logic [31:0] rb;

    checks      = 0;
    failures    = 0;
    last_result = '0;
    rst_n       = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    div_op      = DIV_DIV;
    a           = '0;
    b           = '0;
    tick();
    tick();
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic, issued back-to-back in each DONE cycle.
    run_op("div_100_7", DIV_DIV, 32'd100, 32'd7);
    run_op("rem_100_7", DIV_REM, 32'd100, 32'd7);
    run_op("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_m7_2", DIV_DIVU, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", DIV_DIVU, 32'd5, 32'd0);
    run_op("remu_by0", DIV_REMU, 32'd5, 32'd0);
    run_op("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0_prio", DIV_DIV, 32'h8000_0000, 32'd0);
    run_op("div_7_100", DIV_DIV, 32'd7, 32'd100);
    tick();

    // Flush at cycle 10 abandons the operation; fresh start at cycle 12.
    apply_stimulus(DIV_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_busy", 32'(busy), 32'd0);
    check_output("flush_done", 32'(done), 32'd0);
    check_output("flush_result_held", result, last_result);
    tick();
    check_output("flush_no_done_later", 32'(done), 32'd0);
    run_op("divu_9_3_after_flush", DIV_DIVU, 32'd9, 32'd3);
    tick();

    // Flush and start together: the start is dropped.
    start  = 1'b1;
    flush  = 1'b1;
    div_op = DIV_DIVU;
    a      = 32'd8;
    b      = 32'd0;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check_output("flush_start_busy", 32'(busy), 32'd0);
    check_output("flush_start_done", 32'(done), 32'd0);
    check_output("flush_start_result", result, last_result);

    // Flush during the DONE cycle: visible done stands, new request is not taken.
    run_op("divu_by0_pre_flush", DIV_DIVU, 32'd5, 32'd0);
    flush  = 1'b1;
    start  = 1'b1;
    div_op = DIV_DIVU;
    a      = 32'd8;
    b      = 32'd2;
    tick();
    flush = 1'b0;
    start = 1'b0;
    check_output("flush_in_done_done", 32'(done), 32'd0);
    check_output("flush_in_done_busy", 32'(busy), 32'd0);
    check_output("flush_in_done_result", result, 32'hFFFF_FFFF);
    tick();

    // A second start while busy must be ignored.
    apply_stimulus(DIV_DIV, 32'd1000, 32'd9);
    repeat (4) tick();
    start  = 1'b1;
    div_op = DIV_DIVU;
    a      = 32'd7;
    b      = 32'd0;
    tick();
    start = 1'b0;
    wait_done("start_while_busy", 6, 33, 32'd111);
    tick();

    // Reset at cycle 20 mid-calculation abandons the operation.
    apply_stimulus(DIV_REMU, 32'd12345, 32'd97);
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("midcalc_reset_busy", 32'(busy), 32'd0);
    check_output("midcalc_reset_done", 32'(done), 32'd0);
    check_output("midcalc_reset_result", result, 32'd0);
    done_cnt = 0;
    repeat (20) begin
      tick();
      if (done) done_cnt++;
    end
    check_output("midcalc_reset_no_done", 32'(done_cnt), 32'd0);

    // Random operations with corner-biased operands and occasional idle gaps.
    for (int i = 0; i < 24; i++) begin
      rop = div_op_e'(2'($urandom_range(0, 3)));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'd1;
        3: rb = 32'hFFFF_FFFF;
        4: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
        default: ;
      endcase
      run_op("random_op", rop, ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_output("random_result_hold", result, last_result);
        check_output("random_idle_done", 32'(done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
